branch_predict_resolve: RTL and testbench

- Combined IF-stage branch predictor and EX-stage branch resolver for the 5-stage RV32I pipeline.
- IF side: direct-mapped branch target buffer (BTB). Each entry holds a tag, a target and a saturating counter. It supplies a predicted direction and target for the fetch PC.
- EX side: evaluates the branch condition from fun3 and the comparator flags, detects a misprediction, drives the redirect PC and flush, and trains the table.
- Replaces the purely combinational EX-only branch-taken logic, which had no prediction.

---
 rtl/branch_pkg.sv | 44 ++++
 rtl/branch_predict_resolve_btb_table.sv | 35 +++
 rtl/branch_predict_resolve.sv | 145 ++++++++++++++
 tb/tb_branch_predict_resolve.sv | 539 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the BTB predictor / EX resolver.
// Holds fun3 codes, table geometry, the BTB entry struct and counter helper.
package branch_pkg;

  localparam int BP_XLEN  = 32;
  localparam int BP_DEPTH = 16;
  localparam int BP_CNT_W = 2;
  localparam int BP_IDX_W = $clog2(BP_DEPTH);
  localparam int BP_TAG_W = BP_XLEN - BP_IDX_W - 2;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam logic [BP_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [BP_CNT_W-1:0] CNT_WT  =
    BP_CNT_W'(1) << (BP_CNT_W - 1);
  localparam logic [BP_CNT_W-1:0] CNT_WNT = CNT_WT - 1'b1;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0]  target;
    logic [BP_CNT_W-1:0] cnt;
  } btb_entry_t;

  function automatic logic [BP_CNT_W-1:0] sat_inc_dec(
    input logic [BP_CNT_W-1:0] c,
    input logic                up
  );
    logic [BP_CNT_W-1:0] r;
    r = c;
    if (up) begin
      if (c != CNT_MAX) r = c + 1'b1;
    end else begin
      if (c != '0) r = c - 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_predict_resolve_btb_table.sv
// Direct-mapped BTB storage: two async read ports, one sync write port.
// Ports: clk, rst_n (sync, active-low), rd0/rd1 idx->entry, we/wr_idx/wr_entry.
module btb_table
  import branch_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BP_IDX_W-1:0] rd0_idx,
  output btb_entry_t          rd0_entry,
  input  logic [BP_IDX_W-1:0] rd1_idx,
  output btb_entry_t          rd1_entry,
  input  logic                we,
  input  logic [BP_IDX_W-1:0] wr_idx,
  input  btb_entry_t          wr_entry
);

  btb_entry_t mem [BP_DEPTH];

  assign rd0_entry = mem[rd0_idx];
  assign rd1_entry = mem[rd1_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BP_DEPTH; i++) begin
        mem[i].valid  <= 1'b0;
        mem[i].tag    <= '0;
        mem[i].target <= '0;
        mem[i].cnt    <= CNT_WNT;
      end
    end else if (we) begin
      mem[wr_idx] <= wr_entry;
    end
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// IF-stage BTB prediction plus EX-stage branch resolution and training.
// Optional BRANCH_STATS_EN adds o_br_count / o_mispred_count counters.
module branch_predict_resolve
  import branch_pkg::*;
#(
  parameter int XLEN      = BP_XLEN,
  parameter int BTB_DEPTH = BP_DEPTH,
  parameter int CNT_W     = BP_CNT_W
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_if_pc,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_target,
  input  logic            i_ex_valid,
  input  logic            i_ex_branch,
  input  logic            i_ex_jump,
  input  logic [2:0]      i_ex_fun3,
  input  logic            i_ex_br_equal,
  input  logic            i_ex_br_less,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic [XLEN-1:0] i_ex_target,
  input  logic            i_ex_pred_taken,
  input  logic [XLEN-1:0] i_ex_pred_target,
  output logic            o_ex_taken,
  output logic            o_mispredict,
  output logic [XLEN-1:0] o_redirect_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     o_br_count,
  output logic [31:0]     o_mispred_count
`endif
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  btb_entry_t       if_ent;
  btb_entry_t       ex_ent;
  btb_entry_t       wr_ent;
  logic             if_hit;
  logic             ex_hit;
  logic             active;
  logic             cond;
  logic             legal;
  logic             upd_en;
  logic             we;
  logic             unused_pc;

  assign if_idx = i_if_pc[IDX_W+1:2];
  assign if_tag = i_if_pc[XLEN-1:IDX_W+2];
  assign ex_idx = i_ex_pc[IDX_W+1:2];
  assign ex_tag = i_ex_pc[XLEN-1:IDX_W+2];
  assign unused_pc = ^i_if_pc[1:0];

  btb_table u_btb (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .rd0_idx   (if_idx),
    .rd0_entry (if_ent),
    .rd1_idx   (ex_idx),
    .rd1_entry (ex_ent),
    .we        (we),
    .wr_idx    (ex_idx),
    .wr_entry  (wr_ent)
  );

  assign if_hit = if_ent.valid && (if_ent.tag == if_tag);
  assign o_pred_taken = if_hit && if_ent.cnt[CNT_W-1];
  assign o_pred_target = o_pred_taken ? if_ent.target : '0;

  always_comb begin
    cond  = 1'b0;
    legal = 1'b1;
    unique case (1'b1)
      (i_ex_fun3 == BEQ):  cond = i_ex_br_equal;
      (i_ex_fun3 == BNE):  cond = !i_ex_br_equal;
      (i_ex_fun3 == BLT):  cond = i_ex_br_less;
      (i_ex_fun3 == BGE):  cond = !i_ex_br_less;
      (i_ex_fun3 == BLTU): cond = i_ex_br_less;
      (i_ex_fun3 == BGEU): cond = !i_ex_br_less;
      default:             legal = 1'b0;
    endcase
  end

  assign active = i_ex_valid && (i_ex_branch || i_ex_jump);
  assign o_ex_taken = active && (i_ex_jump || cond);
  // fun3 010/011 resolve not-taken but must not train the table
  assign upd_en = active && (i_ex_jump || legal);

  assign o_mispredict = active &&
    ((o_ex_taken != i_ex_pred_taken) ||
     (o_ex_taken && (i_ex_target != i_ex_pred_target)));

  assign o_redirect_pc = o_ex_taken ? i_ex_target
                                    : i_ex_pc + XLEN'(4);

  assign ex_hit = ex_ent.valid && (ex_ent.tag == ex_tag);

  always_comb begin
    we     = 1'b0;
    wr_ent = ex_ent;
    if (upd_en) begin
      if (ex_hit) begin
        we = 1'b1;
        if (i_ex_jump) begin
          wr_ent.cnt    = CNT_MAX;
          wr_ent.target = i_ex_target;
        end else begin
          wr_ent.cnt = sat_inc_dec(ex_ent.cnt, o_ex_taken);
          if (o_ex_taken) wr_ent.target = i_ex_target;
        end
      end else if (o_ex_taken) begin
        we            = 1'b1;
        wr_ent.valid  = 1'b1;
        wr_ent.tag    = ex_tag;
        wr_ent.target = i_ex_target;
        wr_ent.cnt    = i_ex_jump ? CNT_MAX : CNT_WT;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] br_cnt_q;
  logic [31:0] mis_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (active) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (o_mispredict) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign o_br_count      = br_cnt_q;
  assign o_mispred_count = mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Self-checking bench for branch_predict_resolve.
// Directed scenarios plus randomized traffic against a table model.
module tb_branch_predict_resolve;

  localparam int DEPTH = 16;
  localparam logic [2:0] F_BEQ = 3'b000;
  localparam logic [2:0] F_BNE = 3'b001;
  localparam logic [2:0] F_BAD = 3'b010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_branch, ex_jump;
  logic [2:0]  ex_fun3;
  logic        ex_eq, ex_lt;
  logic [31:0] ex_pc, ex_target;
  logic        ex_ptk;
  logic [31:0] ex_ptgt;
  logic        ex_taken, mispredict;
  logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_count, mis_count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference table state
  bit          m_valid [DEPTH];
  logic [31:0] m_tag   [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  int          m_cnt   [DEPTH];

  // Expected results of the currently driven EX instruction
  bit          e_tk, e_mis, e_upd;
  logic [31:0] e_rd;

  always #5 clk = ~clk;

  branch_predict_resolve dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_if_pc          (if_pc),
    .o_pred_taken     (pred_taken),
    .o_pred_target    (pred_target),
    .i_ex_valid       (ex_valid),
    .i_ex_branch      (ex_branch),
    .i_ex_jump        (ex_jump),
    .i_ex_fun3        (ex_fun3),
    .i_ex_br_equal    (ex_eq),
    .i_ex_br_less     (ex_lt),
    .i_ex_pc          (ex_pc),
    .i_ex_target      (ex_target),
    .i_ex_pred_taken  (ex_ptk),
    .i_ex_pred_target (ex_ptgt),
    .o_ex_taken       (ex_taken),
    .o_mispredict     (mispredict),
    .o_redirect_pc    (redirect_pc)
`ifdef BRANCH_STATS_EN
    ,
    .o_br_count       (br_count),
    .o_mispred_count  (mis_count)
`endif
  );

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] pc);
    return pc / (4 * DEPTH);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_tgt[i]   = 0;
      m_cnt[i]   = 1;
    end
  endfunction

  function automatic void m_predict(
    input  logic [31:0] pc,
    output bit          pt,
    output logic [31:0] tg
  );
    int i;
    bit hit;
    i   = idx_of(pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    pt  = hit && (m_cnt[i] >= 2);
    tg  = pt ? m_tgt[i] : 32'h0;
  endfunction

  // Expected results follow from the current EX inputs
  function automatic void m_resolve();
    bit act;
    act   = ex_valid && (ex_branch || ex_jump);
    e_tk  = 0;
    e_upd = act;
    if (act) begin
      if (ex_jump) e_tk = 1;
      else begin
        case (ex_fun3)
          3'd0:       e_tk = ex_eq;
          3'd1:       e_tk = !ex_eq;
          3'd4, 3'd6: e_tk = ex_lt;
          3'd5, 3'd7: e_tk = !ex_lt;
          default:    e_upd = 0;
        endcase
      end
    end
    e_mis = act && ((e_tk != ex_ptk) ||
                    (e_tk && ex_target != ex_ptgt));
    e_rd  = e_tk ? ex_target : ex_pc + 32'd4;
  endfunction

  function automatic void m_update();
    int i;
    bit hit;
    if (!e_upd) return;
    i   = idx_of(ex_pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(ex_pc));
    if (hit) begin
      if (ex_jump) begin
        m_cnt[i] = 3;
        m_tgt[i] = ex_target;
      end else begin
        if (e_tk) m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
        else      m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        if (e_tk) m_tgt[i] = ex_target;
      end
    end else if (e_tk) begin
      m_valid[i] = 1;
      m_tag[i]   = tag_of(ex_pc);
      m_tgt[i]   = ex_target;
      m_cnt[i]   = ex_jump ? 3 : 2;
    end
  endfunction

  task automatic drive_ex(
    input bit v, input bit br, input bit jp,
    input logic [2:0] f3, input bit eq, input bit lt,
    input logic [31:0] pc, input logic [31:0] tg,
    input bit pt, input logic [31:0] ptg
  );
    ex_valid  = v;
    ex_branch = br;
    ex_jump   = jp;
    ex_fun3   = f3;
    ex_eq     = eq;
    ex_lt     = lt;
    ex_pc     = pc;
    ex_target = tg;
    ex_ptk    = pt;
    ex_ptgt   = ptg;
    m_resolve();
  endtask

  task automatic idle_ex();
    drive_ex(0, 0, 0, 3'd0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  // Model absorbs the resolution, then the edge commits it in the DUT
  task automatic commit();
    m_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_pc = 32'h100;
    idle_ex();
    @(negedge clk);
    @(negedge clk);
    m_reset();
    rst_n = 1'b1;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL rst_pred_taken: got %0b want 0", pred_taken);
    end
    checks++;
    if (pred_target !== 32'h0) begin
      errors++;
      $display("FAIL rst_pred_target: got %0h want 0", pred_target);
    end
    checks++;
    if (ex_taken !== 1'b0) begin
      errors++;
      $display("FAIL rst_ex_taken: got %0b want 0", ex_taken);
    end
    checks++;
    if (mispredict !== 1'b0) begin
      errors++;
      $display("FAIL rst_mispredict: got %0b want 0", mispredict);
    end
    @(negedge clk);
  endtask

  task automatic test_first_alloc();
    if_pc = 32'h100;
    drive_ex(1, 1, 0, F_BEQ, 1, 0, 32'h100, 32'h140, 0, 32'h0);
    #1;
    checks++;
    if (ex_taken !== 1'b1 || mispredict !== 1'b1) begin
      errors++;
      $display("FAIL alloc_resolve: got tk=%0b mis=%0b want 1 1",
               ex_taken, mispredict);
    end
    checks++;
    if (redirect_pc !== 32'h140) begin
      errors++;
      $display("FAIL alloc_redirect: got %0h want 140", redirect_pc);
    end
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL alloc_no_bypass: got %0b want 0", pred_taken);
    end
    commit();
    idle_ex();
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h140) begin
      errors++;
      $display("FAIL alloc_lookup: got %0b/%0h want 1/140",
               pred_taken, pred_target);
    end
    @(negedge clk);
  endtask

  task automatic test_bne_training();
    bit          exp_pred [5] = '{0, 1, 1, 1, 1};
    bit          exp_mis  [5] = '{1, 0, 0, 1, 1};
    bit          pt;
    logic [31:0] ptg;
    bit          ntk;
    for (int k = 0; k < 5; k++) begin
      ntk   = (k >= 3);
      if_pc = 32'h200;
      #1;
      checks++;
      if (pred_taken !== exp_pred[k]) begin
        errors++;
        $display("FAIL bne_pred[%0d]: got %0b want %0b",
                 k, pred_taken, exp_pred[k]);
      end
      m_predict(32'h200, pt, ptg);
      drive_ex(1, 1, 0, F_BNE, ntk, 0, 32'h200, 32'h240, pt, ptg);
      #1;
      checks++;
      if (mispredict !== exp_mis[k]) begin
        errors++;
        $display("FAIL bne_mis[%0d]: got %0b want %0b",
                 k, mispredict, exp_mis[k]);
      end
      if (ntk) begin
        checks++;
        if (redirect_pc !== 32'h204) begin
          errors++;
          $display("FAIL bne_redirect[%0d]: got %0h want 204",
                   k, redirect_pc);
        end
      end
      commit();
    end
    idle_ex();
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      errors++;
      $display("FAIL bne_final_pred: got %0b/%0h want 0/0",
               pred_taken, pred_target);
    end
    @(negedge clk);
  endtask

  task automatic test_jalr_target();
    drive_ex(1, 0, 1, 3'd0, 0, 0, 32'h300, 32'h400, 0, 32'h0);
    commit();
    idle_ex();
    if_pc = 32'h300;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h400) begin
      errors++;
      $display("FAIL jalr_first: got %0b/%0h want 1/400",
               pred_taken, pred_target);
    end
    drive_ex(1, 0, 1, 3'd0, 0, 0, 32'h300, 32'h480, 1, 32'h400);
    #1;
    checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h480) begin
      errors++;
      $display("FAIL jalr_mis: got %0b/%0h want 1/480",
               mispredict, redirect_pc);
    end
    commit();
    idle_ex();
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h480) begin
      errors++;
      $display("FAIL jalr_retarget: got %0b/%0h want 1/480",
               pred_taken, pred_target);
    end
    @(negedge clk);
  endtask

  task automatic test_alias();
    drive_ex(1, 1, 0, F_BEQ, 1, 0, 32'h040, 32'h1000, 0, 32'h0);
    commit();
    idle_ex();
    if_pc = 32'h040;
    #1;
    checks++;
    if (pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL alias_first_hit: got %0b want 1", pred_taken);
    end
    drive_ex(1, 1, 0, F_BEQ, 1, 0, 32'h080, 32'h2000, 0, 32'h0);
    commit();
    idle_ex();
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL alias_evicted: got %0b want 0", pred_taken);
    end
    if_pc = 32'h080;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h2000) begin
      errors++;
      $display("FAIL alias_second: got %0b/%0h want 1/2000",
               pred_taken, pred_target);
    end
    @(negedge clk);
  endtask

  task automatic test_inactive_and_bad_fun3();
    drive_ex(0, 1, 0, F_BEQ, 1, 0, 32'h500, 32'h540, 0, 32'h0);
    #1;
    checks++;
    if (ex_taken !== 1'b0 || mispredict !== 1'b0) begin
      errors++;
      $display("FAIL inactive: got tk=%0b mis=%0b want 0 0",
               ex_taken, mispredict);
    end
    checks++;
    if (redirect_pc !== 32'h504) begin
      errors++;
      $display("FAIL inactive_redirect: got %0h want 504", redirect_pc);
    end
    commit();
    idle_ex();
    if_pc = 32'h500;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL inactive_no_alloc: got %0b want 0", pred_taken);
    end
    drive_ex(1, 1, 0, F_BAD, 1, 1, 32'h600, 32'h640, 1, 32'h640);
    #1;
    checks++;
    if (ex_taken !== 1'b0 || mispredict !== 1'b1 ||
        redirect_pc !== 32'h604) begin
      errors++;
      $display("FAIL bad_fun3: got %0b/%0b/%0h want 0/1/604",
               ex_taken, mispredict, redirect_pc);
    end
    commit();
    idle_ex();
    if_pc = 32'h600;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL bad_fun3_no_alloc: got %0b want 0", pred_taken);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    drive_ex(1, 1, 0, F_BEQ, 1, 0, 32'h700, 32'h7c0, 0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    m_reset();
    rst_n = 1'b1;
    idle_ex();
    if_pc = 32'h700;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_update: got %0b want 0", pred_taken);
    end
    if_pc = 32'h080;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL midrst_cleared: got %0b want 0", pred_taken);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] pc, tg, ptg, ipc, mtg;
    bit          pt, mpt;
    int          kind;
    for (int n = 0; n < 400; n++) begin
      pc = 32'h1000 + ($urandom_range(0, 63) << 2);
      if ($urandom_range(0, 31) == 0) pc = 32'hFFFF_FFFC;
      tg   = 32'h2000 + ($urandom_range(0, 7) << 2);
      kind = $urandom_range(0, 3);
      m_predict(pc, pt, ptg);
      if ($urandom_range(0, 3) == 0) begin
        pt  = $urandom_range(0, 1) == 1;
        ptg = 32'h2000 + ($urandom_range(0, 7) << 2);
      end
      ipc = 32'h1000 + ($urandom_range(0, 63) << 2);
      if_pc = ipc;
      drive_ex($urandom_range(0, 7) != 0, kind >= 2, kind == 1,
               3'($urandom), $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1, pc, tg, pt, ptg);
      m_predict(ipc, mpt, mtg);
      #1;
      checks++;
      if (ex_taken !== e_tk) begin
        errors++;
        $display("FAIL rnd_taken[%0d]: got %0b want %0b",
                 n, ex_taken, e_tk);
      end
      checks++;
      if (mispredict !== e_mis) begin
        errors++;
        $display("FAIL rnd_mis[%0d]: got %0b want %0b",
                 n, mispredict, e_mis);
      end
      checks++;
      if (redirect_pc !== e_rd) begin
        errors++;
        $display("FAIL rnd_redirect[%0d]: got %0h want %0h",
                 n, redirect_pc, e_rd);
      end
      checks++;
      if (pred_taken !== mpt || pred_target !== mtg) begin
        errors++;
        $display("FAIL rnd_pred[%0d]: got %0b/%0h want %0b/%0h",
                 n, pred_taken, pred_target, mpt, mtg);
      end
      commit();
    end
    idle_ex();
    @(negedge clk);
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    bit tk;
    rst_n = 1'b0;
    idle_ex();
    @(negedge clk);
    m_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tk = (i % 3 == 0) && (i < 9);
      drive_ex(1, 1, 0, F_BEQ, tk, 0, 32'h3000 + 32'(i * 4),
               32'h3800, 0, 32'h0);
      commit();
    end
    idle_ex();
    #1;
    checks++;
    if (br_count !== 32'd10 || mis_count !== 32'd3) begin
      errors++;
      $display("FAIL stats_counts: got %0d/%0d want 10/3",
               br_count, mis_count);
    end
    drive_ex(1, 1, 0, F_BEQ, 1, 0, 32'h3000, 32'h3900, 0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    m_reset();
    rst_n = 1'b1;
    idle_ex();
    if_pc = 32'h3000;
    #1;
    checks++;
    if (br_count !== 32'd0 || mis_count !== 32'd0) begin
      errors++;
      $display("FAIL stats_reset: got %0d/%0d want 0/0",
               br_count, mis_count);
    end
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL stats_reset_entry: got %0b want 0", pred_taken);
    end
    if_pc = 32'h300c;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL stats_reset_entry2: got %0b want 0", pred_taken);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    if_pc = 32'h0;
    idle_ex();
    m_reset();
    @(negedge clk);
    test_reset();
    test_first_alloc();
    test_bne_training();
    test_jalr_target();
    test_alias();
    test_inactive_and_bad_fun3();
    test_mid_reset();
    test_random();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
